// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared fetch FSM state encoding and default reset PC.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fetch_unit_pkg;

  // Word address [31:2] of byte address 0x00400000
  localparam logic [29:0] c_reset_pc = 30'h100000;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_DISCARD = 2'd1,
    ST_IDLE    = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_adder30.sv
// ============================================================================
// Module   : adder30
// Purpose  : 30-bit word-address incrementer; wraps 30'h3FFFFFFF to 30'h0.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module adder30 (
  input  logic [29:0] a,
  output logic [29:0] sum
);

  assign sum = a + 30'd1;

endmodule

`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Shift-register instruction buffer; entry 0 is always the head.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 62,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_wr_idx;
  logic             w_pop_eff;
  logic [WIDTH-1:0] w_q [DEPTH];

  assign w_pop_eff = pop && (r_count != '0) && !flush;
  // A pop shifts everything down, so the write slot moves down with it
  assign w_wr_idx  = r_count - CW'(w_pop_eff);
  assign count     = r_count;
  assign head      = w_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(push) - CW'(w_pop_eff);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    if (i < DEPTH - 1) begin : g_shift
      assign w_next = w_q[i+1];
    end else begin : g_last
      assign w_next = r_q;
    end

    assign w_q[i] = r_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (!flush) begin
        if (push && (w_wr_idx == CW'(i))) begin
          r_q <= push_data;
        end else if (w_pop_eff) begin
          r_q <= w_next;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Single-outstanding instruction fetcher with redirect and buffer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [29:0] RESET_PC = c_reset_pc,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [29:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [29:0]   r_pc;
  logic [29:0]   w_pc_nxt;
  logic [29:0]   r_addr;
  logic [29:0]   w_addr_nxt;
  logic [29:0]   w_addr_inc;
  logic [CW-1:0] w_count;
  logic [61:0]   w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_room_push;
  logic          w_room_idle;

  adder30 u_inc (
    .a   (r_addr),
    .sum (w_addr_inc)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (62)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (w_push),
    .push_data ({imem_data, r_addr}),
    .pop       (w_pop),
    .flush     (redirect),
    .count     (w_count),
    .head      (w_head)
  );

  assign w_pop       = inst_valid && inst_ready && !redirect;
  assign w_room_push = (int'(w_count) + 1 - int'(w_pop)) < DEPTH;
  assign w_room_idle = (int'(w_count) - int'(w_pop)) < DEPTH;

  assign imem_req   = (r_state != ST_IDLE);
  assign imem_addr  = r_addr;
  assign inst_valid = (w_count != '0);
  assign inst       = w_head[61:30];
  assign inst_pc    = {w_head[29:0], 2'b00};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_push      = 1'b0;
    case (r_state)
      ST_REQ: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
          if (imem_ack) begin
            w_addr_nxt = redirect_pc;
          end else begin
            // imem_addr must stay put until the stale fetch is acked
            w_state_nxt = ST_DISCARD;
          end
        end else if (imem_ack) begin
          w_push      = 1'b1;
          w_pc_nxt    = w_addr_inc;
          w_addr_nxt  = w_addr_inc;
          w_state_nxt = w_room_push ? ST_REQ : ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
        end
        if (imem_ack) begin
          w_addr_nxt  = w_pc_nxt;
          w_state_nxt = ST_REQ;
        end
      end
      ST_IDLE: begin
        if (redirect) begin
          w_pc_nxt    = redirect_pc;
          w_addr_nxt  = redirect_pc;
          w_state_nxt = ST_REQ;
        end else if (w_room_idle) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_REQ;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 30'h100000, word address [31:2] loaded into PC on reset (byte address 0x00400000).
REQ-002 Parameter DEPTH, default 2, number of instruction buffer entries; legal range 2..4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-005 imem_req  output  1  instruction fetch request to instruction memory.
REQ-006 imem_addr  output  30  word address [31:2] of the pending fetch; driven from a register.
REQ-007 imem_ack  input  1  fetch completes in any cycle where imem_req and imem_ack are both high.
REQ-008 imem_data  input  32  instruction word, valid when imem_ack is high.
REQ-009 inst_valid  output  1  buffer head holds an instruction for decode.
REQ-010 inst  output  32  instruction at the buffer head.
REQ-011 inst_pc  output  32  byte PC of inst; bits [1:0] are always 2'b00.
REQ-012 inst_ready  input  1  decode accepts the head when inst_valid and inst_ready are both high (pop).
REQ-013 redirect  input  1  branch taken; flush and refetch.
REQ-014 redirect_pc  input  30  word address [31:2] of the branch target.

Function
REQ-015 FSM states: REQ (imem_req=1), DISCARD (imem_req=1, response dropped), IDLE (imem_req=0).
REQ-016 At most one fetch is outstanding; imem_addr is held stable from issue until ack.
REQ-017 In REQ, ack without redirect pushes {imem_data, imem_addr} and sets PC and imem_addr to imem_addr+1 (mod 2^30).
REQ-018 After a push, next state is REQ if count+1-pop < DEPTH; otherwise next state is IDLE.
REQ-019 In IDLE, the FSM moves to REQ in the cycle after count drops below DEPTH.
REQ-020 Latency: ack in cycle N makes inst_valid high in cycle N+1; inst and inst_pc come from registers.
REQ-021 Buffer is FIFO-ordered; simultaneous push and pop are both honoured, with the count unchanged.
REQ-022 Redirect flushes all entries (count=0, inst_valid=0 next cycle); any pop in the same cycle is ignored.
REQ-023 Redirect in REQ with ack: the response is dropped; imem_addr=redirect_pc; next state is REQ.
REQ-024 Redirect in REQ without ack: PC=redirect_pc; imem_addr is held; next state is DISCARD.
REQ-025 In DISCARD, ack drops the data, sets imem_addr=PC, and moves to REQ.
REQ-026 In DISCARD, a further redirect overwrites PC only.
REQ-027 Redirect in IDLE: imem_addr=redirect_pc; next state is REQ.
REQ-028 PC and imem_addr wrap from 30'h3FFFFFFF to 30'h0 with no error indication.
REQ-029 imem_ack while imem_req is low is ignored.

Reset
REQ-030 While reset is low: state=REQ, PC=imem_addr=RESET_PC, count=0, inst_valid=0, inst=0, inst_pc=0.
REQ-031 imem_req=1 from the first cycle reset is high.
REQ-032 A reset assertion mid-fetch abandons the outstanding request; imem_ack arriving during reset is ignored.

Structure
REQ-033 FSM state encodings and the default RESET_PC constant belong in the shared package.
REQ-034 The buffer is a sub-module fetch_fifo (push, pop, flush, count, head data).
REQ-035 The PC increment is a 30-bit adder (adder30).

Verification
REQ-036 Reset release, ack every cycle, inst_ready=1 -> inst_pc sequence 0x00400000, 0x00400004, 0x00400008, one instruction per cycle.
REQ-037 inst_ready=0, ack every cycle -> two pushes, then imem_req=0 (IDLE); a single pop produces imem_req=1 in the next cycle.
REQ-038 Redirect to 30'h100040 with no ack, ack after 3 cycles -> that data is dropped; next imem_addr=30'h100040; first inst_pc=0x00400100.
REQ-039 Redirect and ack in the same cycle with the buffer full -> buffer empty next cycle; imem_addr=redirect_pc; no stale instruction delivered.
REQ-040 RESET_PC=30'h3FFFFFFF -> second fetch is at imem_addr 30'h0; inst_pc=0x00000000.
REQ-041 reset driven low mid-wait, asynchronous to clk -> outputs reach reset values before the next edge; fetch restarts at RESET_PC.
